// File: rtl/processor_pkg.sv
// Shared opcode, state and instruction-field definitions for the multi-cycle
// processor core and its ALU.
package processor_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_ADDI = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_MUL  = 4'h4;
  localparam logic [3:0] OP_NEG  = 4'h6;
  localparam logic [3:0] OP_BGEZ = 4'h8;
  localparam logic [3:0] OP_MOVE = 4'hA;
  localparam logic [3:0] OP_ST   = 4'hB;
  localparam logic [3:0] OP_LD   = 4'hC;
  localparam logic [3:0] OP_LI   = 4'hD;
  localparam logic [3:0] OP_J    = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_OPND   = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_HALTED = 3'd5;

  localparam int unsigned IR_W   = 8;
  localparam int unsigned OP_MSB = 7;
  localparam int unsigned OP_LSB = 4;
  localparam int unsigned RD_MSB = 3;
  localparam int unsigned RD_LSB = 2;
  localparam int unsigned RS_MSB = 1;
  localparam int unsigned RS_LSB = 0;

  // Instructions followed by an immediate word.
  function automatic logic has_operand(input logic [3:0] op);
    return op inside {OP_ADDI, OP_BGEZ, OP_ST, OP_LD, OP_LI, OP_J};
  endfunction

  function automatic logic is_illegal(input logic [3:0] op);
    return op inside {4'h5, 4'h7, 4'h9};
  endfunction

  function automatic logic writes_alu(input logic [3:0] op);
    return op inside {OP_ADD, OP_ADDI, OP_SUB, OP_MUL, OP_NEG, OP_MOVE, OP_LI};
  endfunction

endpackage

// File: rtl/processor_alu.sv
// Combinational datapath for register-writing instructions; all results are
// modulo 2^DATA_W.
module processor_alu
  import processor_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] rd_val,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] result
);

  always_comb begin
    result = rd_val;
    case (op)
      OP_ADD:  result = rd_val + rs_val;
      OP_ADDI: result = rd_val + imm;
      OP_SUB:  result = rd_val - rs_val;
      OP_MUL:  result = rd_val * rs_val;
      OP_NEG:  result = '0 - rd_val;
      OP_MOVE: result = rs_val;
      OP_LI:   result = imm;
      default: result = rd_val;
    endcase
  end

endmodule

// File: rtl/processor_core.sv
// Multi-cycle fetch/operand/execute/memory core with a req/ack memory port,
// illegal-opcode trap, saturating cycle counter and register debug read.
module processor_core
  import processor_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 7,
  parameter int unsigned CC_W     = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              halted,
  output logic              err,
  output logic [CC_W-1:0]   cc,
  input  logic [1:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_reg
);

  localparam logic [ADDR_W-1:0] PC0 = ADDR_W'(RESET_PC);

  logic [2:0]        state;
  logic [IR_W-1:0]   ir;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] alu_y;
  logic [ADDR_W-1:0] pc, pc_inc, exec_pc;
  logic [DATA_W-1:0] r [4];
  logic [3:0]        op, fetch_op;
  logic [1:0]        rd, rs;
  logic              xfer, active;

  assign op       = ir[OP_MSB:OP_LSB];
  assign rd       = ir[RD_MSB:RD_LSB];
  assign rs       = ir[RS_MSB:RS_LSB];
  assign fetch_op = mem_rdata[OP_MSB:OP_LSB];
  assign xfer     = mem_req & mem_ack;
  assign active   = state inside {S_FETCH, S_OPND, S_EXEC, S_MEM};
  assign busy     = active;
  assign halted   = (state == S_HALTED);
  assign dbg_reg  = r[dbg_sel];
  assign pc_inc   = pc + ADDR_W'(1);

  // Next fetch address out of EXEC, so the request can be registered there.
  always_comb begin
    exec_pc = pc;
    if (op == OP_J || (op == OP_BGEZ && !r[rd][DATA_W-1]))
      exec_pc = imm[ADDR_W-1:0];
  end

  processor_alu #(.DATA_W(DATA_W)) u_alu (
    .op    (op),
    .rd_val(r[rd]),
    .rs_val(r[rs]),
    .imm   (imm),
    .result(alu_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      err       <= 1'b0;
      cc        <= '0;
      pc        <= PC0;
      ir        <= '0;
      imm       <= '0;
      for (int unsigned i = 0; i < 4; i++) r[i] <= '0;
    end else begin
      if (active && cc != '1) cc <= cc + CC_W'(1);
      case (state)
        S_IDLE, S_HALTED: begin
          if (start) begin
            state    <= S_FETCH;
            pc       <= PC0;
            cc       <= '0;
            err      <= 1'b0;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= PC0;
          end
        end
        S_FETCH: begin
          if (xfer) begin
            ir <= mem_rdata[IR_W-1:0];
            pc <= pc_inc;
            if (has_operand(fetch_op)) begin
              state    <= S_OPND;
              mem_addr <= pc_inc;
            end else begin
              state   <= S_EXEC;
              mem_req <= 1'b0;
            end
          end
        end
        S_OPND: begin
          if (xfer) begin
            imm     <= mem_rdata;
            pc      <= pc_inc;
            state   <= S_EXEC;
            mem_req <= 1'b0;
          end
        end
        S_EXEC: begin
          if (writes_alu(op)) r[rd] <= alu_y;
          pc <= exec_pc;
          if (op == OP_LD || op == OP_ST) begin
            state    <= S_MEM;
            mem_req  <= 1'b1;
            mem_we   <= (op == OP_ST);
            mem_addr <= imm[ADDR_W-1:0];
            if (op == OP_ST) mem_wdata <= r[rd];
          end else if (op == OP_HALT || is_illegal(op)) begin
            state <= S_HALTED;
            err   <= is_illegal(op);
          end else begin
            state    <= S_FETCH;
            mem_req  <= 1'b1;
            mem_addr <= exec_pc;
          end
        end
        S_MEM: begin
          if (xfer) begin
            if (!mem_we) r[rd] <= mem_rdata;
            state    <= S_FETCH;
            mem_we   <= 1'b0;
            mem_addr <= pc;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_processor_core.sv
// Randomised and directed checks of processor_core against an
// instruction-level reference interpreter.
module tb_processor_core;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 7;
  localparam int          MEMSZ = 128;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          mem_req, mem_we;
  logic          mem_ack = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          busy, halted, err;
  logic [7:0]    cc;
  logic [1:0]    dbg_sel = 2'd0;
  logic [DW-1:0] dbg_reg;

  logic          start4 = 1'b0;
  logic          ack4 = 1'b1;
  logic          req4, we4, busy4, halted4, err4;
  logic [AW-1:0] addr4;
  logic [DW-1:0] wdata4, rdata4, dbg4;
  logic [3:0]    cc4;
  logic [1:0]    dbg_sel4 = 2'd0;

  logic [7:0] mem  [MEMSZ];
  logic [7:0] mm   [MEMSZ];
  logic [7:0] mem4 [MEMSZ];
  logic [7:0] mr   [4];

  int checks = 0;
  int failures = 0;
  int ack_mode = 0;
  int req_cnt = 0;
  int stall_cnt = 0;
  int n_writes = 0;
  bit hold_pending = 1'b0;
  logic [AW-1:0] h_addr, last_waddr;
  logic          h_we;
  logic [DW-1:0] h_wdata, last_wdata;

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];
  assign rdata4    = mem4[addr4];

  processor_core #(.DATA_W(8), .ADDR_W(7), .CC_W(8), .RESET_PC(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy), .halted(halted), .err(err), .cc(cc),
    .dbg_sel(dbg_sel), .dbg_reg(dbg_reg)
  );

  processor_core #(.DATA_W(8), .ADDR_W(7), .CC_W(4), .RESET_PC(0)) u_dut_cc4 (
    .clk(clk), .rst_n(rst_n), .start(start4),
    .mem_req(req4), .mem_we(we4), .mem_addr(addr4), .mem_wdata(wdata4),
    .mem_rdata(rdata4), .mem_ack(ack4),
    .busy(busy4), .halted(halted4), .err(err4), .cc(cc4),
    .dbg_sel(dbg_sel4), .dbg_reg(dbg4)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory responder: chooses ack for the next edge and checks that a
  // stalled request is held unchanged.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        check_eq("hold_req",   32'(mem_req),   32'd1);
        check_eq("hold_addr",  32'(mem_addr),  32'(h_addr));
        check_eq("hold_we",    32'(mem_we),    32'(h_we));
        check_eq("hold_wdata", 32'(mem_wdata), 32'(h_wdata));
      end
      case (ack_mode)
        0: mem_ack = 1'b1;
        1: begin
          if (mem_req) begin
            mem_ack = (req_cnt % 3 == 2);
            req_cnt++;
          end else begin
            mem_ack = 1'($urandom);
          end
        end
        2: mem_ack = 1'($urandom);
        default: mem_ack = mem_req && (mem_addr < AW'(32));
      endcase
      if (mem_req && !mem_ack) stall_cnt++;
      hold_pending = mem_req && !mem_ack;
      h_addr  = mem_addr;
      h_we    = mem_we;
      h_wdata = mem_wdata;
    end
  end

  always @(posedge clk) begin
    if (rst_n && mem_req && mem_ack && mem_we) begin
      mem[mem_addr] = mem_wdata;
      last_waddr    = mem_addr;
      last_wdata    = mem_wdata;
      n_writes++;
    end
  end

  function automatic bit op_has_imm(input logic [3:0] op);
    return op inside {4'h2, 4'h8, 4'hB, 4'hC, 4'hD, 4'hE};
  endfunction

  // Instruction-level interpreter; cycle cost follows the published latency table.
  task automatic model_run(output int cyc, output int xf, output bit m_err);
    int pc;
    int rd, rs;
    logic [7:0] w, imm;
    logic [3:0] op;
    pc = 0; cyc = 0; xf = 0; m_err = 1'b0;
    for (int step = 0; step < 500; step++) begin
      w  = mm[pc];
      pc = (pc + 1) % MEMSZ;
      op = w[7:4];
      rd = int'(w[3:2]);
      rs = int'(w[1:0]);
      cyc += 2; xf++;
      imm = 8'h00;
      if (op_has_imm(op)) begin
        imm = mm[pc];
        pc  = (pc + 1) % MEMSZ;
        cyc++; xf++;
      end
      case (op)
        4'h1: mr[rd] = mr[rd] + mr[rs];
        4'h2: mr[rd] = mr[rd] + imm;
        4'h3: mr[rd] = mr[rd] - mr[rs];
        4'h4: mr[rd] = mr[rd] * mr[rs];
        4'h6: mr[rd] = 8'h00 - mr[rd];
        4'h8: if (!mr[rd][7]) pc = int'(imm[6:0]);
        4'hA: mr[rd] = mr[rs];
        4'hB: begin mm[imm[6:0]] = mr[rd]; cyc++; xf++; end
        4'hC: begin mr[rd] = mm[imm[6:0]]; cyc++; xf++; end
        4'hD: mr[rd] = imm;
        4'hE: pc = int'(imm[6:0]);
        4'hF: return;
        4'h5, 4'h7, 4'h9: begin m_err = 1'b1; return; end
        default: ;
      endcase
    end
  endtask

  task automatic put(input int a, input logic [7:0] w);
    mem[a] = w;
    mm[a]  = w;
  endtask

  task automatic clear_prog;
    for (int a = 0; a < 'h60; a++) put(a, 8'hF0);
  endtask

  task automatic do_reset;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) mr[i] = 8'h00;
  endtask

  task automatic pulse_start;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_halt(input string tag);
    int n;
    n = 0;
    while (halted !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_done"}, 32'(halted), 32'd1);
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i);
      #1;
      check_eq($sformatf("%s_r%0d", tag, i), 32'(dbg_reg), 32'(mr[i]));
    end
  endtask

  task automatic run_and_compare(input string tag, input int mode);
    int cyc, xf, exp_cc;
    bit m_err;
    ack_mode = mode; req_cnt = 0; stall_cnt = 0;
    model_run(cyc, xf, m_err);
    pulse_start();
    wait_halt(tag);
    exp_cc = cyc;
    if (mode == 1) exp_cc += 2 * xf;
    else if (mode == 2) exp_cc += stall_cnt;
    if (exp_cc > 255) exp_cc = 255;
    check_eq({tag, "_cc"},   32'(cc),   32'(exp_cc));
    check_eq({tag, "_err"},  32'(err),  32'(m_err));
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    for (int a = 'h60; a < MEMSZ; a++)
      check_eq($sformatf("%s_m%0h", tag, a), 32'(mem[a]), 32'(mm[a]));
    check_regs(tag);
  endtask

  task automatic check_reg_const(input string tag, input int idx, input logic [7:0] exp);
    @(negedge clk);
    dbg_sel = 2'(idx);
    #1;
    check_eq(tag, 32'(dbg_reg), 32'(exp));
  endtask

  function automatic logic [3:0] pick_op;
    case ($urandom_range(0, 11))
      0: return 4'h0;  1: return 4'h1;  2: return 4'h2;  3: return 4'h3;
      4: return 4'h4;  5: return 4'h6;  6: return 4'h8;  7: return 4'hA;
      8: return 4'hB;  9: return 4'hC;  10: return 4'hD;
      default: return 4'hE;
    endcase
  endfunction

  // Straight-line program with forward-only branches so it always terminates.
  task automatic gen_program;
    int n, a;
    int addr [11];
    logic [3:0] ops [10];
    logic [7:0] immv;
    logic [3:0] term;
    clear_prog();
    n = $urandom_range(5, 10);
    a = 0;
    for (int i = 0; i < n; i++) begin
      ops[i]  = pick_op();
      addr[i] = a;
      a += op_has_imm(ops[i]) ? 2 : 1;
    end
    addr[n] = a;
    for (int i = 0; i < n; i++) begin
      put(addr[i], {ops[i], 2'($urandom), 2'($urandom)});
      if (op_has_imm(ops[i])) begin
        case (ops[i])
          4'hB, 4'hC: immv = 8'h60 + 8'($urandom_range(0, 31));
          4'h8, 4'hE: immv = 8'(addr[$urandom_range(i + 1, n)]);
          default:    immv = 8'($urandom);
        endcase
        put(addr[i] + 1, immv);
      end
    end
    case ($urandom_range(0, 5))
      0: term = 4'h5;
      1: term = 4'h7;
      2: term = 4'h9;
      default: term = 4'hF;
    endcase
    put(addr[n], {term, 4'($urandom)});
  endtask

  initial begin
    int cnt;
    bit found;
    for (int a = 0; a < MEMSZ; a++) begin
      put(a, 8'($urandom));
      mem4[a] = 8'hF0;
    end
    mem4[0] = 8'hE0;
    mem4[1] = 8'h00;
    for (int i = 0; i < 4; i++) mr[i] = 8'h00;

    #12;
    check_eq("rst_req",   32'(mem_req),   32'd0);
    check_eq("rst_we",    32'(mem_we),    32'd0);
    check_eq("rst_addr",  32'(mem_addr),  32'd0);
    check_eq("rst_wdata", 32'(mem_wdata), 32'd0);
    check_eq("rst_busy",  32'(busy),      32'd0);
    check_eq("rst_halt",  32'(halted),    32'd0);
    check_eq("rst_err",   32'(err),       32'd0);
    check_eq("rst_cc",    32'(cc),        32'd0);
    check_eq("rst_cc4",   32'(cc4),       32'd0);
    @(negedge clk); rst_n = 1'b1;

    // LI r0,5; LI r1,7; ADD r0,r1; HALT
    clear_prog();
    put(0, 8'hD0); put(1, 8'h05); put(2, 8'hD4); put(3, 8'h07); put(4, 8'h11); put(5, 8'hF0);
    run_and_compare("add0", 0);
    check_eq("add0_cc_abs", 32'(cc), 32'd10);
    check_reg_const("add0_r0_abs", 0, 8'd12);
    check_reg_const("add0_r1_abs", 1, 8'd7);
    run_and_compare("add3", 1);
    check_eq("add3_cc_abs", 32'(cc), 32'd22);
    check_reg_const("add3_r0_abs", 0, 8'd12);

    // LI r2,-1 / 3; BGEZ r2,6; LI r3,1; HALT
    for (int k = 0; k < 2; k++) begin
      do_reset();
      clear_prog();
      put(0, 8'hD8); put(1, (k == 0) ? 8'hFF : 8'h03); put(2, 8'h88); put(3, 8'h06);
      put(4, 8'hDC); put(5, 8'h01); put(6, 8'hF0);
      run_and_compare($sformatf("bgez%0d", k), 0);
      check_reg_const($sformatf("bgez%0d_r3_abs", k), 3, (k == 0) ? 8'd1 : 8'd0);
    end

    // LI r1,0x5A; ST r1,0x40; LD r0,0x40; HALT
    clear_prog();
    put(0, 8'hD4); put(1, 8'h5A); put(2, 8'hB4); put(3, 8'h40); put(4, 8'hC0); put(5, 8'h40); put(6, 8'hF0);
    n_writes = 0;
    run_and_compare("stld", 2);
    check_eq("stld_nwr",   32'(n_writes),   32'd1);
    check_eq("stld_waddr", 32'(last_waddr), 32'h40);
    check_eq("stld_wdata", 32'(last_wdata), 32'h5A);
    check_reg_const("stld_r0_abs", 0, 8'h5A);

    // Illegal opcode trap, then restart from the reset pc
    clear_prog();
    put(0, 8'h50);
    run_and_compare("trap", 0);
    check_eq("trap_err_abs", 32'(err), 32'd1);
    check_eq("trap_cc_abs",  32'(cc),  32'd2);
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (mem_req) cnt++;
    end
    check_eq("trap_noreq", 32'(cnt), 32'd0);
    put(0, 8'hF0);
    pulse_start();
    check_eq("restart_req",  32'(mem_req),  32'd1);
    check_eq("restart_addr", 32'(mem_addr), 32'd0);
    check_eq("restart_err",  32'(err),      32'd0);
    wait_halt("restart");
    check_eq("restart_err2", 32'(err), 32'd0);
    check_eq("restart_cc",   32'(cc),  32'd2);

    // pc wrap: J 0x7D; ADDi r0,3 at 0x7D; J at 0x7F takes its operand from address 0
    do_reset();
    clear_prog();
    put(0, 8'hE0); put(1, 8'h7D); put(2, 8'hF0);
    put('h7D, 8'h20); put('h7E, 8'h03); put('h7F, 8'hE0); put('h60, 8'hF0);
    run_and_compare("wrap", 0);
    check_reg_const("wrap_r0_abs", 0, 8'd3);

    for (int k = 0; k < 12; k++) begin
      gen_program();
      run_and_compare($sformatf("rnd%0d", k), k % 3);
    end

    // Reset while an LD is stalled
    do_reset();
    clear_prog();
    put(0, 8'hD4); put(1, 8'h33); put(2, 8'hB4); put(3, 8'h10); put(4, 8'hC0); put(5, 8'h40); put(6, 8'hF0);
    ack_mode = 3;
    pulse_start();
    found = 1'b0;
    for (int n = 0; n < 60 && !found; n++) begin
      @(negedge clk);
      if (mem_req && !mem_we && mem_addr == AW'('h40)) found = 1'b1;
    end
    check_eq("rstld_reach", 32'(found), 32'd1);
    repeat (2) @(negedge clk);
    check_eq("rstld_busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("rstld_req",   32'(mem_req),   32'd0);
    check_eq("rstld_we",    32'(mem_we),    32'd0);
    check_eq("rstld_addr",  32'(mem_addr),  32'd0);
    check_eq("rstld_wdata", 32'(mem_wdata), 32'd0);
    check_eq("rstld_busy",  32'(busy),      32'd0);
    check_eq("rstld_halt",  32'(halted),    32'd0);
    check_eq("rstld_err",   32'(err),       32'd0);
    check_eq("rstld_cc",    32'(cc),        32'd0);
    for (int i = 0; i < 4; i++) mr[i] = 8'h00;
    check_regs("rstld");
    @(negedge clk); rst_n = 1'b1;
    ack_mode = 0;

    // Saturation of a 4-bit cycle counter on an endless J 0 loop
    @(negedge clk); start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("cc4_mid", 32'(cc4), 32'd10);
    repeat (20) @(negedge clk);
    check_eq("cc4_sat",  32'(cc4),   32'd15);
    check_eq("cc4_busy", 32'(busy4), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
